// File: rtl/cmd_queue_if.sv
// ---------------------------------------------------------------------------
// cmd_queue_if -- host/issuer side signal bundle for cmd_queue.
//
// A command (cmd_t) travels through this bundle as an opaque CMD_W-bit word;
// the queue never looks inside it.
//
// Signals:
//   i_wr_en      host push request
//   i_cmd        command written on an accepted push
//   o_full       queue holds DEPTH entries
//   i_rd         issuer pop request
//   o_cmd        head entry, first-word-fall-through
//   o_empty      queue holds no entries
//   o_count      occupancy, 0..DEPTH
//   i_flush      discard all entries
//   o_overflow   sticky: push attempted while full
//   o_underflow  sticky: pop attempted while empty
//
// Modports:
//   slave   -- the queue itself
//   master  -- the host/issuer side (drives requests, observes status)
// ---------------------------------------------------------------------------
interface cmd_queue_if #(
    parameter int DEPTH = 16,
    parameter int CMD_W = 32
);
    logic                     i_wr_en;
    logic [CMD_W-1:0]         i_cmd;
    logic                     o_full;
    logic                     i_rd;
    logic [CMD_W-1:0]         o_cmd;
    logic                     o_empty;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     i_flush;
    logic                     o_overflow;
    logic                     o_underflow;

    modport slave (
        input  i_wr_en, i_cmd, i_rd, i_flush,
        output o_full, o_cmd, o_empty, o_count, o_overflow, o_underflow
    );

    modport master (
        output i_wr_en, i_cmd, i_rd, i_flush,
        input  o_full, o_cmd, o_empty, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/cmd_queue.sv
// ---------------------------------------------------------------------------
// cmd_queue -- first-word-fall-through command FIFO between a host and a
// command issuer.
//
// Parameters:
//   DEPTH  number of entries; must be a power of two >= 2 so the pointers
//          wrap naturally at DEPTH-1 -> 0
//   CMD_W  width of one command word
//
// Ports:
//   i_clk   single clock, rising edge
//   i_rstn  synchronous active-low reset
//   q       cmd_queue_if.slave bundle (push/pop/flush requests, head data,
//           occupancy and sticky error flags)
//
// Behaviour summary:
//   - push accepted iff i_wr_en && !o_full, pop accepted iff i_rd && !o_empty
//   - simultaneous accepted push and pop leave the count unchanged
//   - flush zeroes pointers and count, beats push/pop, leaves flags alone
//   - o_count/o_full/o_empty are registered; o_cmd is mem[rd_ptr]
// ---------------------------------------------------------------------------
module cmd_queue #(
    parameter int DEPTH = 16,
    parameter int CMD_W = 32
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    cmd_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CMD_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    logic             push_ok;
    logic             pop_ok;
    logic [CNT_W-1:0] count_next;

    // Acceptance is gated on the registered full/empty, so a pop in the same
    // cycle never makes room for a push into a full queue (and vice versa).
    // A flush cycle accepts neither.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_ok    = 1'b0;
        pop_ok     = 1'b0;
        count_next = count;
        if (!q.i_flush) begin
            push_ok = q.i_wr_en && !full;
            pop_ok  = q.i_rd && !empty;
        end
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Control state. Reset is synchronous: it is sampled only on the edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Sticky flags look at the request against the registered status.
            // A push offered during a flush is simply dropped, not an overflow.
            if (q.i_wr_en && full && !q.i_flush) begin
                overflow <= 1'b1;
            end
            if (q.i_rd && empty) begin
                underflow <= 1'b1;
            end

            if (q.i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                full   <= 1'b0;
                empty  <= 1'b1;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count_next;
                full  <= (count_next == CNT_W'(DEPTH));
                empty <= (count_next == '0);
            end
        end
    end

    // Storage array.
    // NOTE: the memory has no reset; pointers and count define which entries
    // are valid, so clearing the array would only cost logic and routing.
    always_ff @(posedge i_clk) begin
        if (i_rstn && push_ok) begin
            mem[wr_ptr] <= q.i_cmd;
        end
    end

    assign q.o_cmd       = mem[rd_ptr];
    assign q.o_count     = count;
    assign q.o_full      = full;
    assign q.o_empty     = empty;
    assign q.o_overflow  = overflow;
    assign q.o_underflow = underflow;

endmodule

// File: tb/tb_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_cmd_queue -- directed bench for cmd_queue at DEPTH=4.
//
// Stimulus drives the bus #1 after a rising edge; status is checked #1 after
// the following edge. Every command the bench expects to be accepted is
// appended to a scoreboard queue; an independent monitor, sampling on the
// falling edge, pops the scoreboard and compares o_cmd whenever the DUT is
// about to accept a pop.
// ---------------------------------------------------------------------------
module tb_cmd_queue;
    localparam int DEPTH = 4;
    localparam int CMD_W = 16;

    logic clk;
    logic rstn;

    cmd_queue_if #(.DEPTH(DEPTH), .CMD_W(CMD_W)) bus ();

    cmd_queue #(.DEPTH(DEPTH), .CMD_W(CMD_W)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .q      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [CMD_W-1:0] sb [$];   // expected pop order
    int               mcount;   // bench-side occupancy used for scoreboard pushes

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a pop will be taken on the next edge, so the head must match.
    always @(negedge clk) begin
        if (rstn && bus.i_rd && !bus.i_flush && !bus.o_empty) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no entry at %0t", bus.o_cmd, $time);
            end else begin
                check("pop_data", 32'(bus.o_cmd), 32'(sb.pop_front()));
            end
        end
    end

    task automatic idle();
        bus.i_wr_en = 1'b0;
        bus.i_cmd   = '0;
        bus.i_rd    = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    // One clock of stimulus; returns #1 after the edge that consumes it.
    task automatic step(input logic wr, input logic [CMD_W-1:0] cmd, input logic rd, input logic fl);
        logic acc_push;
        logic acc_pop;
        bus.i_wr_en = wr;
        bus.i_cmd   = cmd;
        bus.i_rd    = rd;
        bus.i_flush = fl;
        acc_push = wr && !fl && (mcount < DEPTH);
        acc_pop  = rd && !fl && (mcount > 0);
        if (fl) sb.delete();
        else if (acc_push) sb.push_back(cmd);
        @(posedge clk);
        #1;
        if (fl) mcount = 0;
        else mcount = mcount + int'(acc_push) - int'(acc_pop);
        idle();
    endtask

    // One reset cycle with requests asserted, which must be ignored.
    task automatic do_reset();
        rstn        = 1'b0;
        bus.i_wr_en = 1'b1;
        bus.i_cmd   = 16'hDEAD;
        bus.i_rd    = 1'b1;
        bus.i_flush = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle();
        sb.delete();
        mcount = 0;
    endtask

    task automatic check_status(input string tag, input int cnt, input logic full, input logic empty);
        check({tag, "_count"}, 32'(bus.o_count), 32'(cnt));
        check({tag, "_full"},  32'(bus.o_full),  32'(full));
        check({tag, "_empty"}, 32'(bus.o_empty), 32'(empty));
    endtask

    initial begin
        rstn   = 1'b0;
        mcount = 0;
        idle();

        // Reset held two edges with a push request that must be ignored.
        bus.i_wr_en = 1'b1;
        bus.i_cmd   = 16'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0, 1'b0, 1'b1);
        check("reset_ovf", 32'(bus.o_overflow), 32'd0);
        check("reset_unf", 32'(bus.o_underflow), 32'd0);
        rstn = 1'b1;
        idle();

        // Push A,B,C,D; first push accepted on the first edge after release.
        step(1'b1, 16'hA00A, 1'b0, 1'b0);
        check_status("push_a", 1, 1'b0, 1'b0);
        check("head_a", 32'(bus.o_cmd), 32'hA00A);
        step(1'b1, 16'hB00B, 1'b0, 1'b0);
        check_status("push_b", 2, 1'b0, 1'b0);
        check("head_after_b", 32'(bus.o_cmd), 32'hA00A);
        step(1'b1, 16'hC00C, 1'b0, 1'b0);
        check_status("push_c", 3, 1'b0, 1'b0);
        step(1'b1, 16'hD00D, 1'b0, 1'b0);
        check_status("push_d", 4, 1'b1, 1'b0);
        check("ovf_before_e", 32'(bus.o_overflow), 32'd0);
        // Push E into a full queue: dropped, overflow set.
        step(1'b1, 16'hE00E, 1'b0, 1'b0);
        check_status("push_e", 4, 1'b1, 1'b0);
        check("ovf_after_e", 32'(bus.o_overflow), 32'd1);
        // Drain: monitor expects A,B,C,D.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("drain_count", 32'(bus.o_count), 32'(3 - i));
        end
        check("drain_empty", 32'(bus.o_empty), 32'd1);
        check("drain_unf", 32'(bus.o_underflow), 32'd0);

        // Clear the sticky flag, then interleave 6 pushes/6 pops so both
        // pointers wrap past DEPTH-1.
        do_reset();
        check_status("reset2", 0, 1'b0, 1'b1);
        check("reset2_ovf", 32'(bus.o_overflow), 32'd0);
        step(1'b1, 16'h0100, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++) begin
            step(1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
            check("wrap_count", 32'(bus.o_count), 32'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check_status("wrap_end", 0, 1'b0, 1'b1);
        check("wrap_ovf", 32'(bus.o_overflow), 32'd0);
        check("wrap_unf", 32'(bus.o_underflow), 32'd0);

        // Full queue with push and pop together: pop wins, push dropped.
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
        check_status("fill2", 4, 1'b1, 1'b0);
        step(1'b1, 16'h02FF, 1'b1, 1'b0);
        check_status("full_wr_rd", 3, 1'b0, 1'b0);
        check("full_wr_rd_ovf", 32'(bus.o_overflow), 32'd1);
        check("full_wr_rd_head", 32'(bus.o_cmd), 32'h0201);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        check_status("drain2", 0, 1'b0, 1'b1);
        // Empty queue with push and pop together: push wins, underflow set.
        step(1'b1, 16'h0300, 1'b1, 1'b0);
        check_status("empty_wr_rd", 1, 1'b0, 1'b0);
        check("empty_wr_rd_unf", 32'(bus.o_underflow), 32'd1);
        check("empty_wr_rd_head", 32'(bus.o_cmd), 32'h0300);
        check("ovf_sticky", 32'(bus.o_overflow), 32'd1);

        // Reset with two entries queued discards them and clears flags.
        step(1'b1, 16'h0400, 1'b0, 1'b0);
        check("pre_reset_count", 32'(bus.o_count), 32'd2);
        do_reset();
        check_status("mid_reset", 0, 1'b0, 1'b1);
        check("mid_reset_ovf", 32'(bus.o_overflow), 32'd0);
        check("mid_reset_unf", 32'(bus.o_underflow), 32'd0);
        step(1'b1, 16'h0500, 1'b0, 1'b0);
        check_status("post_reset_push", 1, 1'b0, 1'b0);
        check("post_reset_head", 32'(bus.o_cmd), 32'h0500);

        // Flush with 3 entries and a push in the same cycle.
        step(1'b1, 16'h0501, 1'b0, 1'b0);
        step(1'b1, 16'h0502, 1'b0, 1'b0);
        check("pre_flush_count", 32'(bus.o_count), 32'd3);
        step(1'b1, 16'h05FF, 1'b0, 1'b1);
        check_status("flush3", 0, 1'b0, 1'b1);
        check("flush3_ovf", 32'(bus.o_overflow), 32'd0);
        // Flush of a full queue with a push: still no overflow.
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0600 + i), 1'b0, 1'b0);
        check("pre_flush_full", 32'(bus.o_full), 32'd1);
        step(1'b1, 16'h06FF, 1'b0, 1'b1);
        check_status("flush_full", 0, 1'b0, 1'b1);
        check("flush_full_ovf", 32'(bus.o_overflow), 32'd0);
        // Queue restarts cleanly after a flush.
        step(1'b1, 16'h0700, 1'b0, 1'b0);
        check("post_flush_head", 32'(bus.o_cmd), 32'h0700);
        step(1'b0, '0, 1'b1, 1'b0);
        check_status("final", 0, 1'b0, 1'b1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_queue.md
CMD_QUEUE -- requirements
Module: cmd_queue

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of cmd_t entries; legal values are powers of two >= 2.
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rstn  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 i_wr_en  input  1  SHALL be the host push request.
REQ-005 i_cmd  input  $bits(cmd_t)  SHALL be the command pushed when the push is accepted.
REQ-006 o_full  output  1  SHALL be high when the queue holds DEPTH entries.
REQ-007 i_rd  input  1  SHALL be the issuer pop request; it connects to the issuer read-queue output.
REQ-008 o_cmd  output  $bits(cmd_t)  SHALL present the head entry, first-word-fall-through; it connects to the issuer command input.
REQ-009 o_empty  output  1  SHALL be high when the queue holds 0 entries; it connects to the issuer empty-queue input.
REQ-010 o_count  output  $clog2(DEPTH)+1  SHALL give the current occupancy, 0..DEPTH.
REQ-011 i_flush  input  1  SHALL discard all entries.
REQ-012 o_overflow  output  1  SHALL be a sticky flag for a push attempted while full.
REQ-013 o_underflow  output  1  SHALL be a sticky flag for a pop attempted while empty.

Function
REQ-014 Storage SHALL be DEPTH x cmd_t with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH (DEPTH-1 -> 0).
REQ-015 A push SHALL be accepted iff i_wr_en && !o_full; it writes mem[wr_ptr] = i_cmd and increments wr_ptr.
REQ-016 A pop SHALL be accepted iff i_rd && !o_empty; it increments rd_ptr.
REQ-017 Accepted push and accepted pop in the same cycle SHALL both take effect, with o_count unchanged.
REQ-018 Push while full SHALL be dropped even if a pop is accepted in the same cycle: the pop proceeds and count goes to DEPTH-1.
REQ-019 Pop while empty SHALL be ignored even if a push is accepted in the same cycle: the push proceeds and count goes to 1.
REQ-020 o_count, o_full and o_empty SHALL be registered; o_full = (count==DEPTH) and o_empty = (count==0).
REQ-021 o_cmd SHALL equal mem[rd_ptr] combinationally; its value while o_empty=1 is unspecified and unchecked.
REQ-022 Write-to-visible latency SHALL be 1 cycle: a push accepted on edge N into an empty queue gives o_empty=0 and o_cmd=pushed value immediately after edge N.
REQ-023 After an accepted pop on edge N, o_cmd SHALL show the next entry immediately after edge N.
REQ-024 o_overflow SHALL set on an edge with i_wr_en && o_full, and o_underflow SHALL set on an edge with i_rd && o_empty; both SHALL stay set until reset.
REQ-025 i_flush=1 SHALL zero wr_ptr, rd_ptr and count on that edge, with priority over push/pop in the same cycle; storage contents are not cleared and sticky flags are unaffected.
REQ-026 A push presented in a flush cycle SHALL be dropped and SHALL NOT set o_overflow.

Reset
REQ-027 While i_rstn=0 at a rising edge, the block SHALL set pointers=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_underflow=0.
REQ-028 Push/pop/flush requests during reset SHALL be ignored; reset mid-operation SHALL discard all queued commands; the storage array is not reset.
REQ-029 The first push SHALL be accepted on the first edge after i_rstn returns to 1.

Verification (DEPTH=4)
REQ-030 Reset, then push A,B,C on 3 consecutive cycles -> o_count 1,2,3; o_cmd=A from the cycle after the first push; o_empty falls after edge 1.
REQ-031 Fill with A..D, then push E -> o_full=1, o_count=4, E dropped, o_overflow=1; then pop 4 times -> o_cmd sequence A,B,C,D, then o_empty=1.
REQ-032 Push 6 and pop 6 interleaved, so pointers wrap past 3 -> FIFO order preserved, o_count never exceeds 4, no flags set.
REQ-033 Full queue with i_wr_en=1 and i_rd=1 in the same cycle -> head popped, push dropped, o_count=3, o_overflow=1; empty queue with both requests -> o_count=1, o_underflow=1, o_cmd=pushed value.
REQ-034 Queue holding 3 entries, i_flush=1 together with i_wr_en=1 -> next cycle o_count=0, o_empty=1, o_overflow unchanged.
REQ-035 Queue holding 2 entries, i_rstn=0 for one cycle -> o_count=0, o_empty=1, flags 0; a push on the next cycle is visible on o_cmd.
